// File: rtl/cmp_result_tracker.sv
// rtl/cmp_result_tracker.sv - classify, count and debounce 2-bit comparator flag samples
//
// Purpose: registered consumer of a magnitude comparator's gt/eq/lt flags.
//   Each accepted sample is decoded to an outcome code (01 gt, 10 eq, 11 lt).
//   The matching saturating counter is bumped. A run-length filter declares an
//   outcome stable after STABLE_LEN identical samples in a row.
// Optional feature macro: CMP_TRACKER_ONEHOT_CHECK_EN
//   defined   -> multi-hot flags set sticky err and lock the FSM in ERR until clr/rst
//   undefined -> multi-hot flags are priority encoded gt > eq > lt; err is tied 0
// Parameters:
//   CNT_W       width of each outcome counter
//   STABLE_LEN  consecutive identical accepted samples needed for stability (>= 1)
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ena                      block enable; low freezes all state
//   in_valid, gt, eq, lt     sample strobe and comparator flags
//   clr                      synchronous soft clear, same effect as rst
//   gt_cnt, eq_cnt, lt_cnt   saturating per-outcome counts
//   stable, stable_code      stability flag and last declared stable outcome
//   change                   one-cycle pulse on a new stable outcome
//   err                      sticky malformed-flag indicator
module cmp_result_tracker #(
    parameter int CNT_W      = 8,
    parameter int STABLE_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             in_valid,
    input  logic             gt,
    input  logic             eq,
    input  logic             lt,
    input  logic             clr,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic             stable,
    output logic [1:0]       stable_code,
    output logic             change,
    output logic             err
);

    localparam int              RL_W       = $clog2(STABLE_LEN + 1);
    localparam logic [RL_W:0]   RUN_TARGET = (RL_W + 1)'(STABLE_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_STABLE = 2'd2
`ifdef CMP_TRACKER_ONEHOT_CHECK_EN
        , S_ERR  = 2'd3
`endif
    } state_t;

    state_t          state;
    logic [1:0]      last_code;
    logic [RL_W-1:0] run_len;

    logic            any_flag;
    logic            multi_hot;
    logic [1:0]      code;
    logic            offered;
    logic            accept;
    logic            same;
    logic [RL_W:0]   run_len_p1;
    logic            new_run;
    logic            extend;
    logic            go_stable;
    logic            leave_stable;
`ifdef CMP_TRACKER_ONEHOT_CHECK_EN
    logic            bad;
    logic            err_q;
`endif

    always_comb begin
        any_flag  = gt | eq | lt;
        multi_hot = (gt & eq) | (gt & lt) | (eq & lt);
        // Priority encode; only matters for multi-hot when the check is off.
        if (gt)
            code = 2'b01;
        else if (eq)
            code = 2'b10;
        else
            code = 2'b11;
        // An all-zero flag word is never a sample, so it is filtered here.
        offered = ena & in_valid & ~clr & any_flag;
`ifdef CMP_TRACKER_ONEHOT_CHECK_EN
        accept = offered & ~multi_hot & (state != S_ERR);
        bad    = offered & multi_hot & (state != S_ERR);
`else
        accept = offered;
`endif
        // last_code is 00 in IDLE, which never matches a real code.
        same         = (code == last_code);
        run_len_p1   = {1'b0, run_len} + (RL_W + 1)'(1);
        new_run      = accept & ((state == S_IDLE) | ~same);
        extend       = accept & (state == S_RUN) & same;
        go_stable    = (new_run & (STABLE_LEN == 1)) |
                       (extend & (run_len_p1 >= RUN_TARGET));
        leave_stable = accept & (state == S_STABLE) & ~same & ~go_stable;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state       <= S_IDLE;
            last_code   <= 2'b00;
            run_len     <= '0;
            gt_cnt      <= '0;
            eq_cnt      <= '0;
            lt_cnt      <= '0;
            stable      <= 1'b0;
            stable_code <= 2'b00;
            change      <= 1'b0;
`ifdef CMP_TRACKER_ONEHOT_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else if (!ena) begin
            change <= 1'b0;
        end else begin
            change <= 1'b0;

            if (accept) begin
                case (code)
                    2'b01:   if (gt_cnt != CNT_MAX) gt_cnt <= gt_cnt + CNT_ONE;
                    2'b10:   if (eq_cnt != CNT_MAX) eq_cnt <= eq_cnt + CNT_ONE;
                    default: if (lt_cnt != CNT_MAX) lt_cnt <= lt_cnt + CNT_ONE;
                endcase
            end

            if (new_run) begin
                last_code <= code;
                run_len   <= RL_W'(1);
                state     <= S_RUN;
            end

            if (extend)
                run_len <= run_len_p1[RL_W-1:0];

            // Later assignment to state wins over the RUN set by new_run.
            if (go_stable) begin
                state       <= S_STABLE;
                stable      <= 1'b1;
                stable_code <= code;
                // Guarding on the current pulse keeps change from ever being
                // high two cycles in a row (reachable only with STABLE_LEN=1).
                change      <= (code != stable_code) & ~change;
            end else if (leave_stable) begin
                stable <= 1'b0;
            end

`ifdef CMP_TRACKER_ONEHOT_CHECK_EN
            if (bad) begin
                err_q  <= 1'b1;
                state  <= S_ERR;
                stable <= 1'b0;
            end
`endif
        end
    end

`ifdef CMP_TRACKER_ONEHOT_CHECK_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cmp_result_tracker.sv
// tb/tb_cmp_result_tracker.sv - table-driven self-checking bench for cmp_result_tracker
module tb_cmp_result_tracker;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst, ena, in_valid, gt, eq, lt, clr;
    logic [CNT_W-1:0] gt_cnt, eq_cnt, lt_cnt;
    logic             stable, change, err;
    logic [1:0]       stable_code;

    int n_chk  = 0;
    int n_fail = 0;

    cmp_result_tracker #(.CNT_W(CNT_W), .STABLE_LEN(4)) dut (
        .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid),
        .gt(gt), .eq(eq), .lt(lt), .clr(clr),
        .gt_cnt(gt_cnt), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt),
        .stable(stable), .stable_code(stable_code), .change(change), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r, c, e, v;
        logic [2:0] f;
        int         g, q, l;
        logic       st;
        logic [1:0] sc;
        logic       ch;
    } vec_t;

    vec_t tv[$];

    function automatic void add(input logic r, c, e, v, input logic [2:0] f,
                                input int g, q, l, input logic st,
                                input logic [1:0] sc, input logic ch);
        vec_t x;
        x.r = r; x.c = c; x.e = e; x.v = v; x.f = f;
        x.g = g; x.q = q; x.l = l; x.st = st; x.sc = sc; x.ch = ch;
        tv.push_back(x);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic r, c, e, v, input logic [2:0] f);
        rst = r; clr = c; ena = e; in_valid = v;
        {gt, eq, lt} = f;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int g, q, l, input logic st,
                             input logic [1:0] sc, input logic ch, input logic er);
        chk({tag, ".gt_cnt"}, int'(gt_cnt), g);
        chk({tag, ".eq_cnt"}, int'(eq_cnt), q);
        chk({tag, ".lt_cnt"}, int'(lt_cnt), l);
        chk({tag, ".stable"}, int'(stable), int'(st));
        chk({tag, ".stable_code"}, int'(stable_code), int'(sc));
        chk({tag, ".change"}, int'(change), int'(ch));
        chk({tag, ".err"}, int'(err), int'(er));
    endtask

    initial begin
        int n_change;
        rst = 1'b1; clr = 1'b0; ena = 1'b1; in_valid = 1'b0; gt = 1'b0; eq = 1'b0; lt = 1'b0;

        //   r c e v  flags    gt eq  lt st  sc     ch
        add(1,0,1,1, 3'b100,  0, 0,  0, 0, 2'b00, 0);  // reset with flags toggling
        add(1,0,1,1, 3'b010,  0, 0,  0, 0, 2'b00, 0);
        add(0,0,1,1, 3'b100,  1, 0,  0, 0, 2'b00, 0);  // four gt
        add(0,0,1,1, 3'b100,  2, 0,  0, 0, 2'b00, 0);
        add(0,0,1,1, 3'b100,  3, 0,  0, 0, 2'b00, 0);
        add(0,0,1,1, 3'b100,  4, 0,  0, 1, 2'b01, 1);
        add(0,0,1,0, 3'b100,  4, 0,  0, 1, 2'b01, 0);  // no strobe: pulse drops
        add(0,0,1,1, 3'b100,  5, 0,  0, 1, 2'b01, 0);  // stays stable, no pulse
        add(0,1,1,1, 3'b010,  0, 0,  0, 0, 2'b00, 0);  // clr with eq: sample dropped
        add(0,0,1,1, 3'b100,  1, 0,  0, 0, 2'b00, 0);  // gt,gt,gt,eq x4
        add(0,0,1,1, 3'b100,  2, 0,  0, 0, 2'b00, 0);
        add(0,0,1,1, 3'b100,  3, 0,  0, 0, 2'b00, 0);
        add(0,0,1,1, 3'b010,  3, 1,  0, 0, 2'b00, 0);
        add(0,0,1,1, 3'b010,  3, 2,  0, 0, 2'b00, 0);
        add(0,0,1,1, 3'b010,  3, 3,  0, 0, 2'b00, 0);
        add(0,0,1,1, 3'b010,  3, 4,  0, 1, 2'b10, 1);
        add(0,0,1,1, 3'b000,  3, 4,  0, 1, 2'b10, 0);  // 000 flags ignored
        for (int i = 0; i < 5; i++)
            add(0,0,0,1, 3'b001, 3, 4,  0, 1, 2'b10, 0);  // ena low: frozen
        add(0,0,1,1, 3'b001,  3, 4,  1, 0, 2'b10, 0);  // leave stable, code held
        add(0,0,1,1, 3'b010,  3, 5,  1, 0, 2'b10, 0);
        add(0,0,1,1, 3'b010,  3, 6,  1, 0, 2'b10, 0);
        add(0,0,1,1, 3'b010,  3, 7,  1, 0, 2'b10, 0);
        add(0,0,1,1, 3'b010,  3, 8,  1, 1, 2'b10, 0);  // same stable code: no pulse
        add(0,1,0,1, 3'b001,  0, 0,  0, 0, 2'b00, 0);  // clr beats ena low

        foreach (tv[i]) begin
            step(tv[i].r, tv[i].c, tv[i].e, tv[i].v, tv[i].f);
            check_all($sformatf("vec%0d", i), tv[i].g, tv[i].q, tv[i].l,
                      tv[i].st, tv[i].sc, tv[i].ch, 1'b0);
        end

        // 260 lt samples: counter saturates, exactly one change pulse.
        n_change = 0;
        for (int i = 1; i <= 260; i++) begin
            step(0, 0, 1, 1, 3'b001);
            chk($sformatf("lt_run%0d.lt_cnt", i), int'(lt_cnt), (i > 255) ? 255 : i);
            chk($sformatf("lt_run%0d.change", i), int'(change), (i == 4) ? 1 : 0);
            if (change) n_change++;
        end
        chk("lt_run.pulses", n_change, 1);
        check_all("lt_run.end", 0, 0, 255, 1'b1, 2'b11, 1'b0, 1'b0);

        // Multi-hot flags.
        step(0, 1, 1, 0, 3'b000);
        check_all("mh.clr", 0, 0, 0, 1'b0, 2'b00, 1'b0, 1'b0);
        step(0, 0, 1, 1, 3'b110);
`ifdef CMP_TRACKER_ONEHOT_CHECK_EN
        check_all("mh.hit", 0, 0, 0, 1'b0, 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 3'b100);
        check_all("mh.locked", 0, 0, 0, 1'b0, 2'b00, 1'b0, 1'b1);
        step(0, 1, 1, 0, 3'b000);
        check_all("mh.release", 0, 0, 0, 1'b0, 2'b00, 1'b0, 1'b0);
`else
        check_all("mh.hit", 1, 0, 0, 1'b0, 2'b00, 1'b0, 1'b0);
        step(0, 0, 1, 1, 3'b111);
        check_all("mh.hit2", 2, 0, 0, 1'b0, 2'b00, 1'b0, 1'b0);
        step(0, 0, 1, 1, 3'b101);
        step(0, 0, 1, 1, 3'b100);
        check_all("mh.stable", 4, 0, 0, 1'b1, 2'b01, 1'b1, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cmp_result_tracker.md
# cmp_result_tracker

Registered consumer of the 2-bit magnitude comparator's flags (`gt`, `eq`, `lt`), sitting directly downstream of it in the same tile. Each accepted sample is classified, counted per outcome in saturating counters, and run-length filtered. An outcome repeated `STABLE_LEN` times in a row is declared stable, giving the chip a debounced, statistics-bearing view of the comparison stream.

## Interface
- `CNT_W`, 8: width of each outcome counter.
- `STABLE_LEN`, 4: consecutive identical accepted samples needed to declare stability (≥1).

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ena` in 1: high = block active; low = all state frozen.
- `in_valid` in 1: sample strobe for `gt`/`eq`/`lt`.
- `gt`, `eq`, `lt` in 1 each: comparator flags (A>B, A=B, A<B).
- `clr` in 1: synchronous soft clear.
- `gt_cnt`, `eq_cnt`, `lt_cnt` out `CNT_W`: saturating outcome counts.
- `stable` out 1: high while in STABLE.
- `stable_code` out 2: last declared stable outcome (00 none, 01 gt, 10 eq, 11 lt).
- `change` out 1: one-cycle pulse when a new stable outcome is declared.
- `err` out 1: sticky malformed-flag indicator (0 when macro off).

## Operation
- Code: {gt,eq,lt} 100→01, 010→10, 001→11. Accepted sample = `ena & in_valid & !clr` with a valid code.
- 000 is never a valid code: sample ignored, no state change.
- Counters: count of the decoded outcome increments per accepted sample; saturates at 2^CNT_W−1. Never wraps.
- Internal `last_code` (2b) and `run_len` (saturates at STABLE_LEN).
- FSM states IDLE, RUN, STABLE, ERR (ERR only with macro).
  - IDLE: accepted sample → `last_code`=code, `run_len`=1, go RUN (or STABLE directly if STABLE_LEN=1).
  - RUN: code==`last_code` → `run_len`+1; reaching STABLE_LEN → STABLE. Code differs → `last_code`=code, `run_len`=1, stay RUN.
  - STABLE: same code → stay. Different → `last_code`=code, `run_len`=1, go RUN; `stable`=0, `stable_code` holds.
  - ERR: all samples ignored; exits only via `clr` or `rst`.
- On entering STABLE: `stable_code`=code; `change`=1 for that cycle iff code≠previous `stable_code` (first declaration after reset/clr always pulses).
- Priority: `rst` > `clr` > `ena` low > sample. Sample coincident with `clr` is discarded.
- `clr` and `rst` have identical effect: counters, `run_len`, `last_code`, `stable_code`, `err` → 0, state → IDLE.
- `ena` low: no update; `change` forced 0.

## Timing
- All outputs registered; reset value 0 for every output.
- Counter reflects a sample one cycle after the accepting edge.
- `stable`/`stable_code`/`change` update on the edge accepting the STABLE_LEN-th matching sample; visible the following cycle.
- `change` never asserted two consecutive cycles.
- Back-to-back samples every cycle supported; no backpressure.

## Configuration
- `CMP_TRACKER_ONEHOT_CHECK_EN` defined: flags with more than one bit set (e.g. 110, 111) set `err`=1 and move FSM to ERR; sample not counted.
- Undefined: multi-hot flags priority-encoded gt>eq>lt and processed as valid; ERR state absent; `err` tied 0.

## Test plan
- Reset: assert `rst` 2 cycles with flags toggling → all outputs 0, state IDLE.
- Four consecutive gt (100) samples → `gt_cnt`=4, `stable`=1, `stable_code`=01, `change` one-cycle pulse.
- gt,gt,gt,eq,eq,eq,eq → `gt_cnt`=3, `eq_cnt`=4, `stable` first rises after 7th sample, `stable_code`=10.
- 260 lt samples, CNT_W=8 → `lt_cnt`=255 held; after STABLE, further lt samples give no extra `change`.
- Flags 110 with macro → `err`=1, later samples ignored, `clr` restores all zeros; without macro → `gt_cnt` +1.
- `clr` with valid eq in same cycle → all zero, sample dropped; `ena`=0 with 5 samples → outputs unchanged.
